// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative radix-2 divider.
// Holds the operand width, FSM state encoding and divide-by-zero quotient.
package div_iter_pkg;

   localparam int DW = 32;
   localparam int CW = $clog2(DW);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [DW-1:0] DIV_BY_ZERO_QUOT = '1;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation used for signed divides.
// Ports: val (DW) in, neg (1) in, res (DW) out = neg ? -val : val.
module div_sign_fix
   import div_iter_pkg::*;
(
   input  logic [DW-1:0] val,
   input  logic          neg,
   output logic [DW-1:0] res
);

   // DW-bit negation wraps, so the magnitude of the most negative
   // value is that same bit pattern read as unsigned.
   assign res = neg ? (DW'(0) - val) : val;

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider for DIV/DIVU, one quotient bit per cycle.
// Ports: clk, rst (sync, active-high), start, sign, opa, opb, annul in;
//        busy, valid, result = {remainder, quotient} out.
module div_iter
   import div_iter_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          sign,
   input  logic [DW-1:0] opa,
   input  logic [DW-1:0] opb,
   input  logic          annul,
   output logic          busy,
   output logic          valid,
   output logic [2*DW-1:0] result
);

   logic [1:0]      state_q;
   logic [CW-1:0]   cnt_q;
   logic [DW-1:0]   rem_q;
   logic [DW-1:0]   quo_q;
   logic [DW-1:0]   dvs_q;
   logic            sign_q;
   logic            a_neg_q;
   logic            b_neg_q;
   logic            dbz_q;
   logic [2*DW-1:0] result_q;

   logic [DW-1:0]   abs_a;
   logic [DW-1:0]   abs_b;
   logic [DW-1:0]   quo_fix;
   logic [DW-1:0]   rem_fix;

   logic [DW:0]     shifted;
   logic            ge;
   logic [DW-1:0]   rem_nx;
   logic [DW-1:0]   quo_nx;
   logic [2*DW-1:0] fin;
   logic            opb_zero;

   div_sign_fix u_fix_a (
      .val (opa),
      .neg (sign & opa[DW-1]),
      .res (abs_a)
   );

   div_sign_fix u_fix_b (
      .val (opb),
      .neg (sign & opb[DW-1]),
      .res (abs_b)
   );

   div_sign_fix u_fix_q (
      .val (quo_q),
      .neg (sign_q & (a_neg_q ^ b_neg_q)),
      .res (quo_fix)
   );

   div_sign_fix u_fix_r (
      .val (rem_q),
      .neg (sign_q & a_neg_q),
      .res (rem_fix)
   );

   assign opb_zero = (opb == '0);

   // quo_q doubles as the dividend shift register: its MSB feeds the
   // partial remainder while quotient bits enter at the LSB.
   assign shifted = {rem_q, quo_q[DW-1]};
   assign ge      = (shifted >= {1'b0, dvs_q});

   // The partial remainder stays below the divisor, so a kept
   // difference always fits in DW bits.
   assign rem_nx = ge ? (shifted[DW-1:0] - dvs_q) : shifted[DW-1:0];
   assign quo_nx = {quo_q[DW-2:0], ge};

   // On divide by zero quo_q still holds the raw dividend.
   assign fin = dbz_q ? {quo_q, DIV_BY_ZERO_QUOT} : {rem_fix, quo_fix};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         sign_q   <= 1'b0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         dbz_q    <= 1'b0;
         result_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start && !annul) begin
                  sign_q  <= sign;
                  a_neg_q <= sign & opa[DW-1];
                  b_neg_q <= sign & opb[DW-1];
                  dvs_q   <= abs_b;
                  rem_q   <= '0;
                  cnt_q   <= '0;
                  dbz_q   <= opb_zero;
                  quo_q   <= opb_zero ? opa : abs_a;
                  state_q <= opb_zero ? S_DONE : S_CALC;
               end
            end
            S_CALC: begin
               if (annul) begin
                  state_q <= S_IDLE;
               end else begin
                  rem_q <= rem_nx;
                  quo_q <= quo_nx;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CW'(DW - 1))
                     state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               if (!annul)
                  result_q <= fin;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy  = (state_q == S_CALC) || (state_q == S_DONE);
   assign valid = (state_q == S_DONE) && !annul;

   // The finished value is visible in the DONE cycle itself and then
   // held by result_q.
   assign result = valid ? fin : result_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter.
// Each task drives one scenario and checks its outputs inline.
module tb_div_iter;

   logic        clk;
   logic        rst;
   logic        start;
   logic        sign;
   logic        annul;
   logic [31:0] opa;
   logic [31:0] opb;
   logic        busy;
   logic        valid;
   logic [63:0] result;

   int tests;
   int fails;

   div_iter dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .sign   (sign),
      .opa    (opa),
      .opb    (opb),
      .annul  (annul),
      .busy   (busy),
      .valid  (valid),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Raise start in the current cycle (cycle 0); returns in cycle 1.
   task automatic go(input logic s, input logic [31:0] a,
                     input logic [31:0] b);
      sign  = s;
      opa   = a;
      opb   = b;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Cycle-bounded wait for valid; cyc = -1 when it never came.
   task automatic wait_valid(input int lim, output int cyc,
                             output logic [63:0] r);
      cyc = -1;
      r   = '0;
      for (int c = 1; c <= lim; c++) begin
         if (valid) begin
            cyc = c;
            r   = result;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
      tests++;
      if (valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_valid got %b want 0", valid);
      end
      tests++;
      if (result !== 64'h0) begin
         fails++;
         $display("FAIL reset_result got %h want 0", result);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_unsigned();
      int          bad;
      int          vcyc;
      int          nval;
      logic [63:0] r;
      bad  = 0;
      vcyc = -1;
      nval = 0;
      r    = '0;
      go(1'b0, 32'd100, 32'd7);
      for (int c = 1; c <= 33; c++) begin
         if (busy !== 1'b1) bad++;
         if (valid === 1'b1) begin
            nval++;
            vcyc = c;
            r    = result;
         end
         if (c < 33) step();
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL udiv_busy low in %0d cycles want 0", bad);
      end
      tests++;
      if (vcyc != 33 || nval != 1) begin
         fails++;
         $display("FAIL udiv_valid_cycle got %0d (n=%0d) want 33", vcyc, nval);
      end
      tests++;
      if (r !== 64'h00000002_0000000E) begin
         fails++;
         $display("FAIL udiv_result got %h want 000000020000000e", r);
      end
      step();
      tests++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         fails++;
         $display("FAIL udiv_idle busy=%b valid=%b want 0 0", busy, valid);
      end
   endtask

   task automatic test_signed();
      int          vcyc;
      logic [63:0] r;
      go(1'b1, 32'hFFFFFFF9, 32'h00000002);
      wait_valid(40, vcyc, r);
      tests++;
      if (vcyc != 33) begin
         fails++;
         $display("FAIL sdiv_valid_cycle got %0d want 33", vcyc);
      end
      tests++;
      if (r !== 64'hFFFFFFFF_FFFFFFFD) begin
         fails++;
         $display("FAIL sdiv_result got %h want fffffffffffffffd", r);
      end
      step();
   endtask

   task automatic test_overflow();
      int          vcyc;
      logic [63:0] r;
      go(1'b1, 32'h80000000, 32'hFFFFFFFF);
      wait_valid(40, vcyc, r);
      tests++;
      if (vcyc != 33) begin
         fails++;
         $display("FAIL ovf_valid_cycle got %0d want 33", vcyc);
      end
      tests++;
      if (r !== 64'h00000000_80000000) begin
         fails++;
         $display("FAIL ovf_result got %h want 0000000080000000", r);
      end
      step();
   endtask

   task automatic test_div_zero();
      int          vcyc;
      logic [63:0] r;
      go(1'b1, 32'h12345678, 32'h0);
      wait_valid(40, vcyc, r);
      tests++;
      if (vcyc != 1) begin
         fails++;
         $display("FAIL dbz_valid_cycle got %0d want 1", vcyc);
      end
      tests++;
      if (r !== 64'h12345678_FFFFFFFF) begin
         fails++;
         $display("FAIL dbz_result got %h want 12345678ffffffff", r);
      end
      step();
      tests++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         fails++;
         $display("FAIL dbz_idle busy=%b valid=%b want 0 0", busy, valid);
      end
   endtask

   // Runs right after test_div_zero, so the held result is its output.
   task automatic test_annul();
      int          nval;
      int          vcyc;
      logic [63:0] r;
      nval = 0;
      go(1'b0, 32'd1000, 32'd10);
      for (int c = 1; c < 10; c++) begin
         if (valid === 1'b1) nval++;
         step();
      end
      annul = 1'b1;
      if (valid === 1'b1) nval++;
      step();
      annul = 1'b0;
      tests++;
      if (nval != 0) begin
         fails++;
         $display("FAIL annul_no_valid got %0d valids want 0", nval);
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL annul_idle busy got %b want 0", busy);
      end
      tests++;
      if (result !== 64'h12345678_FFFFFFFF) begin
         fails++;
         $display("FAIL annul_result got %h want 12345678ffffffff", result);
      end
      go(1'b0, 32'd1000, 32'd7);
      wait_valid(40, vcyc, r);
      tests++;
      if (vcyc != 33) begin
         fails++;
         $display("FAIL annul_restart_cycle got %0d want 33", vcyc);
      end
      tests++;
      if (r !== 64'h00000006_0000008E) begin
         fails++;
         $display("FAIL annul_restart_result got %h want 000000060000008e", r);
      end
      step();
   endtask

   task automatic test_annul_start();
      sign  = 1'b0;
      opa   = 32'd9;
      opb   = 32'd3;
      start = 1'b1;
      annul = 1'b1;
      step();
      start = 1'b0;
      annul = 1'b0;
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL annul_start busy got %b want 0", busy);
      end
      step();
   endtask

   task automatic test_start_ignored();
      int          nval;
      int          vcyc;
      logic [63:0] r;
      nval = 0;
      vcyc = -1;
      r    = '0;
      go(1'b0, 32'd100, 32'd7);
      for (int c = 1; c <= 40; c++) begin
         if (c == 5 || c == 20) begin
            opa   = 32'd50;
            opb   = 32'd5;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (valid === 1'b1) begin
            nval++;
            vcyc = c;
            r    = result;
         end
         step();
      end
      start = 1'b0;
      tests++;
      if (nval != 1 || vcyc != 33) begin
         fails++;
         $display("FAIL ignore_valid got n=%0d at %0d want 1 at 33", nval, vcyc);
      end
      tests++;
      if (r !== 64'h00000002_0000000E) begin
         fails++;
         $display("FAIL ignore_result got %h want 000000020000000e", r);
      end
   endtask

   task automatic test_reset_mid();
      int nval;
      nval = 0;
      go(1'b0, 32'd100, 32'd7);
      for (int c = 1; c < 15; c++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_busy got %b want 0", busy);
      end
      tests++;
      if (result !== 64'h0) begin
         fails++;
         $display("FAIL rstmid_result got %h want 0", result);
      end
      for (int c = 0; c < 40; c++) begin
         if (valid === 1'b1) nval++;
         step();
      end
      tests++;
      if (nval != 0) begin
         fails++;
         $display("FAIL rstmid_no_valid got %0d valids want 0", nval);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst   = 1'b1;
      start = 1'b0;
      sign  = 1'b0;
      annul = 1'b0;
      opa   = '0;
      opb   = '0;
      test_reset();
      test_unsigned();
      test_signed();
      test_overflow();
      test_div_zero();
      test_annul();
      test_annul_start();
      test_start_ignored();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit radix-2 divider for the EX stage of the MIPS pipeline, serving DIV/DIVU once the decoder flags an instruction as a divide and qualifies it as signed or unsigned. It accepts one operation per start pulse, runs a fixed-length restoring division, and returns {remainder, quotient} for the HI/LO write. Busy drives the pipeline stall logic, which holds the divide in EX until valid. Annul aborts an in-flight divide on exception flush.

## Interface
- DW, 32, operand width; the iteration count equals DW.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; the operands and the sign bit are sampled on the same edge.
- sign  in  1  1 = DIV (signed), 0 = DIVU.
- opa  in  DW  dividend (rs).
- opb  in  DW  divisor (rt).
- annul  in  1  abort the current operation (pipeline flush).
- busy  out  1  high while an operation is in progress; the stall unit keeps EX frozen while this is high.
- valid  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  2*DW  {remainder (HI), quotient (LO)}; holds its value until the next accepted start.

## Operation
- The FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - start && !annul: latch |opa|, |opb|, the operand signs and sign, and clear the count.
  - If opb == 0, go to DONE; otherwise go to CALC.
- CALC: one restoring step per cycle.
  - Shift {partial_rem, dividend} left by 1.
  - Trial-subtract the divisor using a DW+1-bit subtraction.
  - If the difference is non-negative, keep it and shift in a quotient bit of 1; otherwise restore and shift in 0.
  - After DW steps, go to DONE.
- DONE:
  - Signed fix-up: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - Drive result and pulse valid, then return to IDLE.
- Divide by zero returns quotient = all ones and remainder = opa, unmodified by the sign fix-up.
- 0x80000000 / 0xFFFFFFFF (signed) returns quotient 0x80000000 and remainder 0. No trap is raised.
- Magnitudes use DW-bit unsigned two's-complement negation, so |0x80000000| = 0x80000000.
- A start seen while busy or in DONE is ignored; the stall logic guarantees this does not occur in normal use.
- annul in CALC or DONE:
  - Go to IDLE on the next edge.
  - No valid is issued and result keeps its previous value.
- annul together with start in IDLE: annul wins and the operation is not accepted.
- Reset:
  - State = IDLE; busy = 0, valid = 0, result = 0.
  - All internal registers are cleared.
  - Reset takes priority over annul and start, including during CALC.

## Timing
- Cycle 0: start is high and sampled.
- Normal divide:
  - Cycles 1..DW (1..32): CALC, busy = 1.
  - Cycle DW+1 (33): DONE, busy = 1, valid = 1, result valid.
  - Cycle 34: IDLE; a new start is accepted here at the earliest.
- Divide by zero:
  - Cycle 1: DONE with valid = 1.
  - Cycle 2: IDLE.
- busy is combinational from state (CALC or DONE). Nothing outside DONE is registered to the outputs.
- valid is high in DONE only and never appears in two consecutive cycles.
- The result register is written only in DONE.

## Structure
- Shared package: the DW default, the FSM state encoding (IDLE/CALC/DONE as 2-bit localparams), and the DIV_BY_ZERO_QUOT constant (all ones).
- One sub-module, div_sign_fix, is natural: combinational magnitude conversion on entry and negation on exit, reused for both operands and both results.
- The iteration datapath and the FSM stay in div_iter.

## Test plan
- Unsigned 100 / 7, start at cycle 0 -> valid at cycle 33, result = {0x00000002, 0x0000000E}; busy is high in cycles 1..33.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, valid at cycle 33.
- Divisor 0, opa = 0x12345678 -> valid at cycle 1, result = {0x12345678, 0xFFFFFFFF}.
- annul at cycle 10 of a divide -> IDLE at cycle 11, no valid, result unchanged; a new start at cycle 11 completes at cycle 44.
- Hold start high in cycles 5 and 20 during a divide -> both ignored, exactly one valid at cycle 33. Assert rst at cycle 15 -> busy = 0 and result = 0 at cycle 16, and no valid follows.
